// File: rtl/video_compositor.sv
// video_compositor
//   Two-stage pixel compositor placed in front of the TMDS encoder. It merges
//   NUM_LAYERS keyed RGB layers and the camera overlay path under one of four
//   modes. The mode and the layer-enable mask are latched only on a vsync
//   rising edge, so a frame is never composited with two different settings.
//
// Ports
//   clk_pixel_in          pixel clock
//   rst_n_in              asynchronous active-low reset
//   layer_pixel_in        RGB888 per layer, layer i at [24i+23:24i]
//   layer_key_in          per-layer opaque flag
//   camera_y_in           camera luma
//   thresholded_pixel_in  threshold mask
//   crosshair_in          crosshair pixel
//   hcount_in             current column
//   hsync_in/vsync_in/active_in  timing aligned with the pixel inputs
//   mode_in               requested mode (0 PRIORITY, 1 CAMERA, 2 BLEND, 3 BARS)
//   layer_en_in           requested layer-enable mask
//   pixel_out             composited RGB, forced black while blanked
//   hsync_out/vsync_out/active_out  timing delayed by two cycles
//   mode_active_out       mode currently in force
module video_compositor #(
  parameter int          NUM_LAYERS = 4,
  parameter logic [23:0] BG_COLOR   = 24'h000000,
  parameter int          BAR_W      = 160,
  parameter int          HCOUNT_W   = 11
) (
  input  logic                       clk_pixel_in,
  input  logic                       rst_n_in,
  input  logic [24*NUM_LAYERS-1:0]   layer_pixel_in,
  input  logic [NUM_LAYERS-1:0]      layer_key_in,
  input  logic [7:0]                 camera_y_in,
  input  logic                       thresholded_pixel_in,
  input  logic                       crosshair_in,
  input  logic [HCOUNT_W-1:0]        hcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       active_in,
  input  logic [1:0]                 mode_in,
  input  logic [NUM_LAYERS-1:0]      layer_en_in,
  output logic [23:0]                pixel_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       active_out,
  output logic [1:0]                 mode_active_out
);

  typedef enum logic [1:0] {
    MODE_PRIORITY = 2'd0,
    MODE_CAMERA   = 2'd1,
    MODE_BLEND    = 2'd2,
    MODE_BARS     = 2'd3
  } mode_e;

  // Number of bar boundaries that can fall inside the hcount range.
  localparam int NUM_BARS = ((1 << HCOUNT_W) + BAR_W - 1) / BAR_W;

  // Bar index by comparator chain (BAR_W need not be a power of two); the
  // 3-bit truncation gives the modulo-8 wrap.
  function automatic logic [23:0] bar_color(input logic [HCOUNT_W-1:0] hc);
    logic [2:0]  idx;
    logic [23:0] col;
    idx = 3'd0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (int'(hc) >= k * BAR_W) idx = 3'(k);
    end
    case (idx)
      3'd0:    col = 24'hFFFFFF;
      3'd1:    col = 24'hFFFF00;
      3'd2:    col = 24'h00FFFF;
      3'd3:    col = 24'h00FF00;
      3'd4:    col = 24'hFF00FF;
      3'd5:    col = 24'hFF0000;
      3'd6:    col = 24'h0000FF;
      default: col = 24'h000000;
    endcase
    return col;
  endfunction

  // Halving both operands first keeps the sum within 8 bits.
  function automatic logic [7:0] half_sum(input logic [7:0] a, input logic [7:0] b);
    return (a >> 1) + (b >> 1);
  endfunction

  logic                      r_vsync_prev;
  mode_e                     r_mode_q;
  logic [NUM_LAYERS-1:0]     r_en_q;
  logic                      w_vsync_rise;

  logic [24*NUM_LAYERS-1:0]  r_layer_p1;
  logic [NUM_LAYERS-1:0]     r_key_p1;
  logic [7:0]                r_y_p1;
  logic                      r_thr_p1;
  logic                      r_xh_p1;
  logic [23:0]               r_bar_p1;
  mode_e                     r_mode_p1;
  logic                      r_hsync_p1;
  logic                      r_vsync_p1;
  logic                      r_active_p1;

  logic [23:0]               r_pixel_p2;
  logic                      r_hsync_p2;
  logic                      r_vsync_p2;
  logic                      r_active_p2;

  logic                      w_prio_hit;
  logic [23:0]               w_prio_pix;
  logic [23:0]               w_l0;
  logic [23:0]               w_l1;
  logic [23:0]               w_blend;
  logic [23:0]               w_mux;

  assign w_vsync_rise = vsync_in & ~r_vsync_prev;

  // The edge detector resets to 1 so a vsync held high through reset
  // release is not taken as an edge; it must go low and high again.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vsync_prev <= 1'b1;
      r_mode_q     <= MODE_PRIORITY;
      r_en_q       <= '1;
    end else begin
      r_vsync_prev <= vsync_in;
      if (w_vsync_rise) begin
        r_mode_q <= mode_e'(mode_in);
        r_en_q   <= layer_en_in;
      end
    end
  end

  // ---- stage 1: register inputs, effective keys and bar colour ----
  // The mode travels with the pixel so a frame-boundary change never
  // splits a pixel between two modes.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_layer_p1  <= '0;
      r_key_p1    <= '0;
      r_y_p1      <= '0;
      r_thr_p1    <= 1'b0;
      r_xh_p1     <= 1'b0;
      r_bar_p1    <= '0;
      r_mode_p1   <= MODE_PRIORITY;
      r_hsync_p1  <= 1'b0;
      r_vsync_p1  <= 1'b0;
      r_active_p1 <= 1'b0;
    end else begin
      r_layer_p1  <= layer_pixel_in;
      r_key_p1    <= layer_key_in & r_en_q;
      r_y_p1      <= camera_y_in;
      r_thr_p1    <= thresholded_pixel_in;
      r_xh_p1     <= crosshair_in;
      r_bar_p1    <= bar_color(hcount_in);
      r_mode_p1   <= r_mode_q;
      r_hsync_p1  <= hsync_in;
      r_vsync_p1  <= vsync_in;
      r_active_p1 <= active_in;
    end
  end

  always_comb begin
    w_prio_hit = 1'b0;
    w_prio_pix = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_key_p1[i]) begin
        w_prio_hit = 1'b1;
        w_prio_pix = r_layer_p1[24*i +: 24];
      end
    end
  end

  always_comb begin
    w_l0    = r_key_p1[0] ? r_layer_p1[23:0]  : BG_COLOR;
    w_l1    = r_key_p1[1] ? r_layer_p1[47:24] : BG_COLOR;
    w_blend = {half_sum(w_l0[23:16], w_l1[23:16]),
               half_sum(w_l0[15:8],  w_l1[15:8]),
               half_sum(w_l0[7:0],   w_l1[7:0])};
  end

  always_comb begin
    w_mux = w_prio_pix;
    case (r_mode_p1)
      MODE_PRIORITY: w_mux = w_prio_pix;
      MODE_CAMERA: begin
        if (r_xh_p1)         w_mux = 24'h00FF00;
        else if (r_thr_p1)   w_mux = 24'hFF77AA;
        else if (w_prio_hit) w_mux = w_prio_pix;
        else                 w_mux = {r_y_p1, r_y_p1, r_y_p1};
      end
      MODE_BLEND:    w_mux = w_blend;
      MODE_BARS:     w_mux = r_bar_p1;
      default:       w_mux = w_prio_pix;
    endcase
  end

  // ---- stage 2: register mode mux result with blanking ----
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pixel_p2  <= '0;
      r_hsync_p2  <= 1'b0;
      r_vsync_p2  <= 1'b0;
      r_active_p2 <= 1'b0;
    end else begin
      r_pixel_p2  <= r_active_p1 ? w_mux : 24'h000000;
      r_hsync_p2  <= r_hsync_p1;
      r_vsync_p2  <= r_vsync_p1;
      r_active_p2 <= r_active_p1;
    end
  end

  assign pixel_out       = r_pixel_p2;
  assign hsync_out       = r_hsync_p2;
  assign vsync_out       = r_vsync_p2;
  assign active_out      = r_active_p2;
  assign mode_active_out = r_mode_q;

endmodule

// File: tb/tb_video_compositor.sv
// Testbench for video_compositor: directed checks with literal expectations
// followed by randomized traffic compared against a behavioural model.
module tb_video_compositor;

  localparam int          NL = 4;
  localparam logic [23:0] BG = 24'h000000;
  localparam int          BW = 160;
  localparam int          HW = 11;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [24*NL-1:0]   layer_pixel_in = '0;
  logic [NL-1:0]      layer_key_in = '0;
  logic [7:0]         camera_y_in = '0;
  logic               thresholded_pixel_in = 1'b0;
  logic               crosshair_in = 1'b0;
  logic [HW-1:0]      hcount_in = '0;
  logic               hsync_in = 1'b0;
  logic               vsync_in = 1'b0;
  logic               active_in = 1'b0;
  logic [1:0]         mode_in = '0;
  logic [NL-1:0]      layer_en_in = '1;
  logic [23:0]        pixel_out;
  logic               hsync_out;
  logic               vsync_out;
  logic               active_out;
  logic [1:0]         mode_active_out;

  video_compositor #(
    .NUM_LAYERS(NL), .BG_COLOR(BG), .BAR_W(BW), .HCOUNT_W(HW)
  ) dut (
    .clk_pixel_in(clk), .rst_n_in(rst_n),
    .layer_pixel_in(layer_pixel_in), .layer_key_in(layer_key_in),
    .camera_y_in(camera_y_in), .thresholded_pixel_in(thresholded_pixel_in),
    .crosshair_in(crosshair_in), .hcount_in(hcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
    .mode_in(mode_in), .layer_en_in(layer_en_in),
    .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .active_out(active_out), .mode_active_out(mode_active_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] pix;
    logic        hs;
    logic        vs;
    logic        act;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic [1:0]  mode_m = 2'd0;
  logic [NL-1:0] en_m = '1;
  logic        prev_m = 1'b1;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_model(input int hc);
    case ((hc / BW) % 8)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(
    input logic [1:0] m, input logic [NL-1:0] en, input logic [24*NL-1:0] lp,
    input logic [NL-1:0] k, input logic [7:0] y, input logic th, input logic ch,
    input int hc);
    logic [NL-1:0] ek;
    logic [23:0]   top;
    logic [23:0]   l0;
    logic [23:0]   l1;
    logic [23:0]   r;
    logic          hit;
    ek  = k & en;
    top = BG;
    hit = 1'b0;
    r   = '0;
    for (int i = 0; i < NL; i++) begin
      if (ek[i] && !hit) begin
        hit = 1'b1;
        top = lp[24*i +: 24];
      end
    end
    case (m)
      2'd0: r = top;
      2'd1: begin
        if (ch)       r = 24'h00FF00;
        else if (th)  r = 24'hFF77AA;
        else if (hit) r = top;
        else          r = {y, y, y};
      end
      2'd2: begin
        l0 = ek[0] ? lp[23:0]  : BG;
        l1 = ek[1] ? lp[47:24] : BG;
        for (int c = 0; c < 3; c++)
          r[8*c +: 8] = 8'((int'(l0[8*c +: 8]) / 2) + (int'(l1[8*c +: 8]) / 2));
      end
      default: r = bar_model(hc);
    endcase
    return r;
  endfunction

  // One pixel cycle: predict the output for the current inputs, advance the
  // model's frame-latched settings, then clock.
  task automatic cyc();
    exp_t e;
    e.pix = active_in ? model_pix(mode_m, en_m, layer_pixel_in, layer_key_in, camera_y_in,
                                  thresholded_pixel_in, crosshair_in, int'(hcount_in))
                      : 24'h000000;
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.act = active_in;
    if (vsync_in && !prev_m) begin
      mode_m = mode_in;
      en_m   = layer_en_in;
    end
    prev_m = vsync_in;
    q.push_back(e);
    @(posedge clk);
    #2;
    chk("mode_active", 24'(mode_active_out), 24'(mode_m));
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_pixel", pixel_out, 24'h000000);
    chk("rst_timing", {21'd0, hsync_out, vsync_out, active_out}, 24'd0);
    chk("rst_mode", 24'(mode_active_out), 24'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    q.push_back('0);
    mode_m = 2'd0;
    en_m   = '1;
    prev_m = 1'b1;
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (q.size() == 0) begin
        chk("queue_underflow", 24'd1, 24'd0);
      end else begin
        e = q.pop_front();
        chk("pixel", pixel_out, e.pix);
        chk("timing", {21'd0, hsync_out, vsync_out, active_out}, {21'd0, e.hs, e.vs, e.act});
      end
    end
  end

  initial begin
    int          hcs[5];
    logic [23:0] bexp[5];
    hcs  = '{0, 159, 160, 1279, 2047};
    bexp = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'hFF00FF};

    // Model pins
    chk("model_bar2047", bar_model(2047), 24'hFF00FF);
    chk("model_blend", model_pix(2'd2, '1, {24'h0, 24'h0, 24'h0000FF, 24'hFF0000},
                                 4'b0011, 8'h00, 1'b0, 1'b0, 0), 24'h7F007F);
    chk("model_cam_y", model_pix(2'd1, '1, '0, 4'b0000, 8'h40, 1'b0, 1'b0, 0), 24'h404040);

    #2;
    do_reset();

    // Reset / latency
    active_in = 1'b1;
    hsync_in  = 1'b1;
    layer_pixel_in[23:0] = 24'h123456;
    layer_key_in = 4'b0001;
    cyc();
    chk("lat_early", pixel_out, 24'h000000);
    hsync_in = 1'b0;
    cyc();
    chk("lat_pixel", pixel_out, 24'h123456);
    chk("lat_active", 24'(active_out), 24'd1);

    // Priority / enable
    layer_pixel_in = {24'h000000, 24'h00BB00, 24'hAA0000, 24'h123456};
    layer_key_in = 4'b0110;
    cyc(); cyc();
    chk("prio_l1", pixel_out, 24'hAA0000);
    vsync_in = 1'b1;
    layer_en_in = 4'b1101;
    cyc();
    vsync_in = 1'b0;
    layer_en_in = 4'b1111;
    cyc(); cyc();
    chk("prio_en_l2", pixel_out, 24'h00BB00);
    layer_key_in = 4'b0000;
    cyc(); cyc();
    chk("prio_bg", pixel_out, BG);

    // Frame-locked mode change
    layer_key_in = 4'b0110;
    mode_in = 2'd1;
    cyc(); cyc();
    chk("mid_mode_hold", 24'(mode_active_out), 24'd0);
    chk("mid_mode_pixel", pixel_out, 24'h00BB00);
    vsync_in = 1'b1;
    cyc();
    vsync_in = 1'b0;
    chk("cam_mode_on", 24'(mode_active_out), 24'd1);
    crosshair_in = 1'b1;
    thresholded_pixel_in = 1'b1;
    cyc(); cyc();
    chk("cam_cross", pixel_out, 24'h00FF00);
    crosshair_in = 1'b0;
    cyc(); cyc();
    chk("cam_thresh", pixel_out, 24'hFF77AA);
    thresholded_pixel_in = 1'b0;
    layer_key_in = 4'b0000;
    camera_y_in = 8'h40;
    cyc(); cyc();
    chk("cam_luma", pixel_out, 24'h404040);

    // Reset mid-frame, vsync held high across release
    mode_in = 2'd2;
    vsync_in = 1'b1;
    do_reset();
    layer_key_in = 4'b0010;
    cyc(); cyc();
    chk("post_rst_en", pixel_out, 24'hAA0000);
    chk("post_rst_mode", 24'(mode_active_out), 24'd0);
    vsync_in = 1'b0;
    cyc();
    vsync_in = 1'b1;
    cyc();
    vsync_in = 1'b0;
    chk("blend_mode_on", 24'(mode_active_out), 24'd2);

    // Blend
    layer_pixel_in = {24'h0, 24'h0, 24'h0000FF, 24'hFF0000};
    layer_key_in = 4'b0011;
    cyc(); cyc();
    chk("blend_both", pixel_out, 24'h7F007F);
    layer_key_in = 4'b0001;
    cyc(); cyc();
    chk("blend_l0", pixel_out, 24'h7F0000);

    // Bars and blanking
    mode_in = 2'd3;
    vsync_in = 1'b1;
    cyc();
    vsync_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hcount_in = HW'(hcs[i]);
      cyc(); cyc();
      chk("bars", pixel_out, bexp[i]);
    end
    active_in = 1'b0;
    cyc(); cyc();
    chk("blank", pixel_out, 24'h000000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      layer_pixel_in = {$urandom, $urandom, $urandom};
      layer_key_in   = NL'($urandom);
      layer_en_in    = NL'($urandom);
      mode_in        = 2'($urandom);
      camera_y_in    = 8'($urandom);
      thresholded_pixel_in = ($urandom_range(0, 3) == 0);
      crosshair_in   = ($urandom_range(0, 7) == 0);
      hcount_in      = HW'($urandom_range(0, 2047));
      hsync_in       = 1'($urandom);
      active_in      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) vsync_in = ~vsync_in;
      cyc();
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/video_compositor.md
# video_compositor

Pipelined, parametrised pixel compositor that replaces the single-select video mux between the pixel sources (staff renderer layers, camera luma, threshold mask, crosshair) and the HDMI/TMDS encoder. It merges NUM_LAYERS keyed RGB layers plus the camera overlay path under one of four frame-locked modes. It delays hsync/vsync/active to stay aligned with the registered pixel output. Mode and layer-enable changes take effect only at a frame boundary, so no frame tears mid-scan.

## Interface
- NUM_LAYERS, 4: number of RGB layers, range 2..8; layer 0 has highest priority.
- BG_COLOR, 24'h000000: output colour when no enabled layer is keyed in.
- BAR_W, 160: colour-bar width in pixels for test-pattern mode.
- HCOUNT_W, 11: width of hcount_in.

- clk_pixel_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- layer_pixel_in  input  24*NUM_LAYERS  RGB 8:8:8 per layer; layer i at bits [24i+23:24i].
- layer_key_in  input  NUM_LAYERS  1 = layer i pixel opaque this cycle, 0 = transparent.
- camera_y_in  input  8  camera luma.
- thresholded_pixel_in  input  1  threshold mask.
- crosshair_in  input  1  crosshair pixel.
- hcount_in  input  HCOUNT_W  current column.
- hsync_in, vsync_in, active_in  input  1 each  timing from the video sig gen, aligned with the pixel inputs.
- mode_in  input  2  requested mode: 0 PRIORITY, 1 CAMERA, 2 BLEND, 3 BARS.
- layer_en_in  input  NUM_LAYERS  requested layer-enable mask.
- pixel_out  output  24  composited RGB.
- hsync_out, vsync_out, active_out  output  1 each  timing delayed to match pixel_out.
- mode_active_out  output  2  mode currently in force.

## Operation
- Frame-boundary latch: a vsync_in rising edge is detected against a registered copy of vsync_in. On that cycle, mode_in and layer_en_in are captured into mode_q and en_q. Values present on the edge cycle are the ones captured. Changes at any other time are ignored until the next edge.
- The effective key of layer i is layer_key_in[i] & en_q[i].
- PRIORITY: output the lowest-index layer whose effective key is 1; if none, output BG_COLOR.
- CAMERA: priority order is crosshair → 24'h00FF00, then thresholded_pixel_in → 24'hFF77AA, then lowest-index keyed layer, then {y,y,y}.
- BLEND: per channel, (L0>>1)+(L1>>1). L0 and L1 are each the layer pixel if its effective key is 1, else BG_COLOR. Each channel is 8 bits and cannot overflow. Layers ≥2 are ignored.
- BARS: bar index = hcount_in / BAR_W, modulo 8. Colours by index 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. BAR_W is not required to be a power of 2; the division is a comparator chain or a counter that resets at hcount_in==0.
- Blanking: when the delayed active is 0, pixel_out is forced to 24'h000000.
- Reset values: pixel_out=0; hsync_out, vsync_out, active_out=0; mode_q=0 (PRIORITY); en_q=all ones; mode_active_out=0; all pipeline registers=0.

## Timing
- Fixed latency of 2 clk_pixel_in cycles from inputs to every output.
- Stage 1 registers the inputs, per-layer effective keys and bar colour.
- Stage 2 registers the mode mux and the blanking.
- hsync_out, vsync_out and active_out equal their inputs delayed exactly 2 cycles.
- mode_q/en_q update on the vsync edge cycle and apply to pixels entering on the following cycle. mode_active_out reflects mode_q with no added delay.
- Throughput is one pixel per cycle with no stalls and no backpressure.
- Asserting reset mid-frame clears all outputs immediately (asynchronously). After release, the first 2 output cycles carry the zeroed pipeline. Mode stays PRIORITY until the next vsync rising edge.
- vsync_in held high across reset release: no edge is detected until vsync_in goes low and then high again.

## Test plan
- Reset/latency: hold rst_n_in=0, then release and drive active_in=1 with layer0=24'h123456 keyed. pixel_out=0 during reset; 24'h123456 appears exactly 2 cycles after the input; active_out tracks active_in +2.
- Priority/enable: keys=4'b0110, layer1=AA0000, layer2=00BB00 → AA0000. After a vsync edge with layer_en_in=4'b1101 → 00BB00. With keys=0 → BG_COLOR.
- Frame-locked mode: drive mode_in=1 mid-frame → mode_active_out stays 0 and output is unchanged until the vsync rising edge. Then crosshair=1 → 00FF00; threshold only → FF77AA; nothing keyed with y=8'h40 → 404040.
- Blend: mode 2, L0=FF0000 and L1=0000FF both keyed → 7F007F; L1 unkeyed with BG=000000 → 7F0000.
- Bars/blanking: mode 3, hcount_in=0, 159, 160, 1279 → FFFFFF, FFFFFF, FFFF00, 000000. active_in=0 → pixel_out=0 regardless of mode.
- Reset mid-frame: pulse rst_n_in low while in mode 1 → all outputs 0 at once; after release, mode_active_out=0 and en_q is all ones.
